// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter and sequencer in front of a single-port word memory.
// Data port has fixed priority; fetch port is forced through after MAX_WAIT lost arbitrations.
module mem_arbiter #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned MAX_WAIT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // memory side
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        mem_writemem,
  output logic        mem_readmem,
  input  logic [31:0] mem_readdata
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] starve_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic             we_q;
  logic             oor_q;
  logic             readmem_q;
  logic             writemem_q;
  logic             i_rvalid_q;
  logic             i_err_q;
  logic [DW-1:0]    i_rdata_q;
  logic             d_rvalid_q;
  logic             d_err_q;
  logic [DW-1:0]    d_rdata_q;

  logic             grant_i_c;
  logic             grant_d_c;
  logic             i_oor_c;
  logic             d_oor_c;
  logic             starve_full_c;

  // Full-width unsigned range check; high address bits are never dropped.
  assign i_oor_c       = (i_addr >= AW'(MEM_WORDS));
  assign d_oor_c       = (d_addr >= AW'(MEM_WORDS));
  assign starve_full_c = (starve_q == CNT_W'(MAX_WAIT));

  // Arbitration in IDLE: data wins ties unless fetch has lost MAX_WAIT times in a row.
  always_comb begin
    grant_i_c = 1'b0;
    grant_d_c = 1'b0;
    if (state_q == ST_IDLE) begin
      if (i_req && d_req) begin
        if (starve_full_c) grant_i_c = 1'b1;
        else               grant_d_c = 1'b1;
      end else if (i_req) begin
        grant_i_c = 1'b1;
      end else if (d_req) begin
        grant_d_c = 1'b1;
      end
    end
  end

  // Sequencer: latch the granted request, drive the memory for one cycle, return a response pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      oor_q      <= 1'b0;
      readmem_q  <= 1'b0;
      writemem_q <= 1'b0;
      i_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      i_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      readmem_q  <= 1'b0;
      writemem_q <= 1'b0;
      i_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant_i_c) begin
            state_q   <= ST_SERVE_I;
            addr_q    <= i_addr;
            we_q      <= 1'b0;
            oor_q     <= i_oor_c;
            readmem_q <= !i_oor_c;
            starve_q  <= '0;
          end else if (grant_d_c) begin
            state_q    <= ST_SERVE_D;
            addr_q     <= d_addr;
            we_q       <= d_we;
            oor_q      <= d_oor_c;
            readmem_q  <= !d_oor_c && !d_we;
            writemem_q <= !d_oor_c && d_we;
            if (d_we && !d_oor_c) wdata_q <= d_wdata;
            if (i_req && !starve_full_c) starve_q <= starve_q + CNT_W'(1);
          end
        end
        ST_SERVE_I: begin
          state_q    <= ST_IDLE;
          i_rvalid_q <= 1'b1;
          i_err_q    <= oor_q;
          i_rdata_q  <= oor_q ? '0 : mem_readdata;
        end
        ST_SERVE_D: begin
          state_q    <= ST_IDLE;
          d_rvalid_q <= 1'b1;
          d_err_q    <= oor_q;
          if (oor_q)      d_rdata_q <= '0;
          else if (!we_q) d_rdata_q <= mem_readdata;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign i_ready       = grant_i_c;
  assign d_ready       = grant_d_c;
  assign i_rvalid      = i_rvalid_q;
  assign i_rdata       = i_rdata_q;
  assign i_err         = i_err_q;
  assign d_rvalid      = d_rvalid_q;
  assign d_rdata       = d_rdata_q;
  assign d_err         = d_err_q;
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;
  assign mem_writemem  = writemem_q;
  assign mem_readmem   = readmem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, transaction drivers, reference model and response scoreboard.
module tb_mem_arbiter;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned MAX_WAIT  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ready, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_writemem, mem_readmem;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_WORDS(MEM_WORDS), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_writedata(mem_writedata), .mem_writemem(mem_writemem),
    .mem_readmem(mem_readmem), .mem_readdata(mem_readdata)
  );

  // Single-port word memory: synchronous write, combinational read gated by readmem.
  logic [31:0] mem_arr [0:1023];
  always @(posedge clk) if (mem_writemem) mem_arr[mem_address[9:0]] <= mem_writedata;
  assign mem_readdata = mem_readmem ? mem_arr[mem_address[9:0]] : 32'h0;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int gap; } txn_t;
  typedef struct { logic [31:0] data; logic err; int due; } exp_t;

  txn_t iq[$], dq[$];
  exp_t iexp[$], dexp[$];
  byte  glog[$];
  logic [31:0] ref_mem [0:1023];

  int n_vec = 0, n_err = 0, cyc = 0;
  bit i_taken = 0, d_taken = 0;
  int unsigned starve_m = 0;
  bit in_serve = 0, m_gi, m_gd;
  logic srv_we = 0, srv_oor = 0;
  logic [31:0] srv_addr = '0, srv_wdata = '0, d_rdata_m = '0;
  exp_t m_e, mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit oor(input logic [31:0] a);
    return a >= 32'(MEM_WORDS);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_flags"}, 32'({i_ready, i_rvalid, i_err, d_ready, d_rvalid, d_err,
                              mem_writemem, mem_readmem}), 32'h0);
    chk({tag, "_i_rdata"}, i_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
    chk({tag, "_mem_address"}, mem_address, 32'h0);
    chk({tag, "_mem_writedata"}, mem_writedata, 32'h0);
  endtask

  // Reference model: arbitration rules, memory contents, expected responses and strobes.
  always @(negedge clk) begin
    if (!rst) begin
      in_serve  = 0;
      starve_m  = 0;
      d_rdata_m = '0;
      i_taken   = 0;
      d_taken   = 0;
      iexp.delete();
      dexp.delete();
    end else begin
      if (in_serve) begin
        chk("mem_readmem", 32'(mem_readmem), 32'(!srv_oor && !srv_we));
        chk("mem_writemem", 32'(mem_writemem), 32'(!srv_oor && srv_we));
        if (!srv_oor) chk("mem_address", mem_address, srv_addr);
        if (!srv_oor && srv_we) begin
          chk("mem_writedata", mem_writedata, srv_wdata);
          ref_mem[srv_addr[9:0]] = srv_wdata;
        end
      end else begin
        chk("mem_strobes_idle", 32'({mem_writemem, mem_readmem}), 32'h0);
      end
      m_gi = 0;
      m_gd = 0;
      if (!in_serve) begin
        if (i_req && (!d_req || starve_m == MAX_WAIT)) m_gi = 1;
        else if (d_req)                                m_gd = 1;
      end
      chk("ready", 32'({i_ready, d_ready}), 32'({m_gi, m_gd}));
      if (i_ready) i_taken = 1;
      if (d_ready) d_taken = 1;
      if (m_gi) begin
        m_e.err  = oor(i_addr);
        m_e.data = m_e.err ? 32'h0 : ref_mem[i_addr[9:0]];
        m_e.due  = cyc + 2;
        iexp.push_back(m_e);
        starve_m = 0;
        glog.push_back("I");
        srv_we  = 1'b0;
        srv_addr = i_addr;
        srv_oor = oor(i_addr);
      end
      if (m_gd) begin
        m_e.err = oor(d_addr);
        if (m_e.err)   d_rdata_m = 32'h0;
        else if (!d_we) d_rdata_m = ref_mem[d_addr[9:0]];
        m_e.data = d_rdata_m;
        m_e.due  = cyc + 2;
        dexp.push_back(m_e);
        if (i_req && starve_m < MAX_WAIT) starve_m++;
        glog.push_back("D");
        srv_we    = d_we;
        srv_addr  = d_addr;
        srv_wdata = d_wdata;
        srv_oor   = oor(d_addr);
      end
      in_serve = m_gi || m_gd;
    end
  end

  // Response monitor: pops the scoreboard whenever a response pulse appears.
  always @(negedge clk) begin
    if (rst) begin
      if (i_rvalid) begin
        if (iexp.size() == 0) fail("i_rvalid_unexpected");
        else begin
          mon_e = iexp.pop_front();
          chk("i_rdata", i_rdata, mon_e.data);
          chk("i_err", 32'(i_err), 32'(mon_e.err));
          chk("i_latency", 32'(cyc), 32'(mon_e.due));
        end
      end else if (iexp.size() > 0 && iexp[0].due <= cyc) begin
        void'(iexp.pop_front());
        fail("i_rvalid_missing");
      end
      if (d_rvalid) begin
        if (dexp.size() == 0) fail("d_rvalid_unexpected");
        else begin
          mon_e = dexp.pop_front();
          chk("d_rdata", d_rdata, mon_e.data);
          chk("d_err", 32'(d_err), 32'(mon_e.err));
          chk("d_latency", 32'(cyc), 32'(mon_e.due));
        end
      end else if (dexp.size() > 0 && dexp[0].due <= cyc) begin
        void'(dexp.pop_front());
        fail("d_rvalid_missing");
      end
    end
  end

  // Drivers: present queued transactions, hold each until accepted.
  initial begin
    txn_t t;
    forever begin
      @(posedge clk);
      #1;
      if (i_req && i_taken) begin i_req = 1'b0; i_taken = 0; end
      if (!i_req && iq.size() > 0) begin
        if (iq[0].gap > 0) begin t = iq[0]; t.gap--; iq[0] = t; end
        else begin t = iq.pop_front(); i_addr = t.addr; i_req = 1'b1; end
      end
      if (d_req && d_taken) begin d_req = 1'b0; d_taken = 0; end
      if (!d_req && dq.size() > 0) begin
        if (dq[0].gap > 0) begin t = dq[0]; t.gap--; dq[0] = t; end
        else begin
          t = dq.pop_front();
          d_we = t.we; d_addr = t.addr; d_wdata = t.wdata; d_req = 1'b1;
        end
      end
    end
  end

  task automatic push_i(input logic [31:0] a, input int gap);
    txn_t t;
    t.we = 1'b0; t.addr = a; t.wdata = '0; t.gap = gap;
    iq.push_back(t);
  endtask

  task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input int gap);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = wd; t.gap = gap;
    dq.push_back(t);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (iq.size() == 0 && dq.size() == 0 && !i_req && !d_req &&
          iexp.size() == 0 && dexp.size() == 0) begin
        repeat (2) @(negedge clk);
        return;
      end
    end
    fail({tag, "_idle_timeout"});
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return 32'd1024;
      1:       return $urandom | 32'h8000_0000;
      2:       return 32'h0001_0000 | 32'($urandom_range(0, 1023));
      default: return 32'd990 + 32'($urandom_range(0, 33));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog_expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    string exp_g;
    bit    found;
    for (int k = 0; k < 1024; k++) begin
      mem_arr[k] = 32'(k * 7 + 3);
      ref_mem[k] = 32'(k * 7 + 3);
    end
    mem_arr[1000] = 13; mem_arr[1001] = 5; mem_arr[1002] = 50; mem_arr[1003] = 4; mem_arr[1004] = 12;
    ref_mem[1000] = 13; ref_mem[1001] = 5; ref_mem[1002] = 50; ref_mem[1003] = 4; ref_mem[1004] = 12;

    // Reset, then idle with no requests.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check_reset_outputs("idle");

    // Data write 999<=77, then fetch read of the same word.
    push_d(1'b1, 32'd999, 32'd77, 0);
    push_i(32'd999, 3);
    wait_idle("wr_rd");
    chk("i_rdata_999", i_rdata, 32'd77);

    // Continuous contention: grant pattern D,D,D,I repeating.
    glog.delete();
    for (int k = 0; k < 8; k++) begin
      push_i(32'(100 + k), 0);
      push_d(1'b0, 32'(200 + k), 32'h0, 0);
    end
    wait_idle("contention");
    exp_g = "DDDIDDDI";
    if (glog.size() < 8) fail("grant_log_short");
    else for (int k = 0; k < 8; k++) chk($sformatf("grant_order_%0d", k), 32'(glog[k]), 32'(exp_g[k]));

    // Out-of-range accesses on both ports.
    push_d(1'b0, 32'd1024, 32'h0, 0);
    push_d(1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0);
    push_d(1'b0, 32'h0001_0005, 32'h0, 1);
    push_i(32'h8000_0000, 2);
    wait_idle("oor");
    chk("d_rdata_after_oor", d_rdata, 32'h0);

    // Back-to-back data reads of the preloaded block.
    for (int k = 0; k < 5; k++) push_d(1'b0, 32'(1000 + k), 32'h0, 0);
    wait_idle("b2b");
    chk("d_rdata_1004", d_rdata, 32'd12);

    // Reset in the middle of a write: strobe drops at once, write and response are lost.
    push_d(1'b1, 32'd1001, 32'd99, 0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (d_ready) found = 1;
    end
    if (!found) fail("rst_wr_no_grant");
    @(posedge clk);
    #2;
    chk("wm_before_reset", 32'(mem_writemem), 32'h1);
    rst = 1'b0;
    #1;
    chk("wm_async_drop", 32'(mem_writemem), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    #2;
    rst = 1'b1;
    push_d(1'b0, 32'd1001, 32'h0, 1);
    wait_idle("rst_rd");
    chk("d_rdata_1001", d_rdata, 32'd5);

    // Randomised mixed traffic.
    for (int k = 0; k < 150; k++) begin
      push_i(rand_addr(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      push_d(1'($urandom_range(0, 1)), rand_addr(), $urandom,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    wait_idle("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
